// File: rtl/nibble_unswap_rx.sv
// Reassembles bytes from a serial nibble stream (optionally undoing a nibble swap)
// and queues them in a small FIFO with valid/ready handshakes on both sides.
module nibble_unswap_rx #(
  parameter int SWAP  = 1,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [3:0] nib_in,
  input  logic       nib_valid,
  output logic       nib_ready,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] byte_cnt,
  output logic       half_pend
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {LO_WAIT, HI_WAIT} state_t;

  state_t           state, state_next;
  logic [3:0]       first_nib, first_nib_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       mem [DEPTH];
  logic [7:0]       byte_asm;
  logic             nib_fire;
  logic             push;
  logic             pop;

  // Ready depends only on registered state, so the sender never sees a path from out_ready.
  assign nib_ready = !((state == HI_WAIT) && (count == FULL));
  assign nib_fire  = nib_valid && nib_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign half_pend = (state == HI_WAIT);
  assign data_out  = out_valid ? mem[rd_ptr] : 8'h00;

  generate
    if (SWAP != 0) begin : g_swap
      assign byte_asm = {nib_in, first_nib};
    end else begin : g_pass
      assign byte_asm = {first_nib, nib_in};
    end
  endgenerate

  always_comb begin
    state_next     = state;
    first_nib_next = first_nib;
    push           = 1'b0;
    if (flush) begin
      state_next = LO_WAIT;
    end else begin
      case (state)
        LO_WAIT: begin
          if (nib_fire) begin
            first_nib_next = nib_in;
            state_next     = HI_WAIT;
          end
        end
        HI_WAIT: begin
          if (nib_fire) begin
            push       = 1'b1;
            state_next = LO_WAIT;
          end
        end
        default: state_next = LO_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LO_WAIT;
      first_nib <= 4'h0;
    end else begin
      state     <= state_next;
      first_nib <= first_nib_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; out_valid masks any entry that was never written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_asm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 8'h00;
    end else if (pop) begin
      byte_cnt <= byte_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_nibble_unswap_rx.sv
// Randomised and directed bench for nibble_unswap_rx: queue-based model per instance,
// per-cycle comparison, plus literal expectations for the key scenarios.
module tb_nibble_unswap_rx;

  localparam int DA = 2;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] nib_in_a, nib_in_b;
  logic       nib_valid_a, nib_valid_b;
  logic       out_ready_a, out_ready_b;
  logic       nib_ready_a, nib_ready_b;
  logic [7:0] data_out_a, data_out_b;
  logic       out_valid_a, out_valid_b;
  logic [7:0] byte_cnt_a, byte_cnt_b;
  logic       half_pend_a, half_pend_b;

  always #5 clk = ~clk;

  nibble_unswap_rx #(.SWAP(1), .DEPTH(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .nib_in(nib_in_a), .nib_valid(nib_valid_a), .nib_ready(nib_ready_a),
    .data_out(data_out_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .byte_cnt(byte_cnt_a), .half_pend(half_pend_a)
  );

  nibble_unswap_rx #(.SWAP(0), .DEPTH(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .nib_in(nib_in_b), .nib_valid(nib_valid_b), .nib_ready(nib_ready_b),
    .data_out(data_out_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .byte_cnt(byte_cnt_b), .half_pend(half_pend_b)
  );

  // Behavioural model: a queue of completed bytes, a held-nibble flag and a pop counter.
  logic [7:0] qa[$], qb[$];
  logic       ha, hb;
  logic [3:0] fa, fb;
  logic [7:0] ca, cb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete(); qb.delete();
      ha = 1'b0; hb = 1'b0; fa = 4'h0; fb = 4'h0; ca = 8'h00; cb = 8'h00;
    end else if (flush) begin
      qa.delete(); qb.delete();
      ha = 1'b0; hb = 1'b0;
    end else begin
      automatic bit rdy_a = !(ha && qa.size() == DA);
      automatic bit rdy_b = !(hb && qb.size() == DB);
      if (qa.size() != 0 && out_ready_a) begin void'(qa.pop_front()); ca = ca + 8'h01; end
      if (qb.size() != 0 && out_ready_b) begin void'(qb.pop_front()); cb = cb + 8'h01; end
      if (nib_valid_a && rdy_a) begin
        if (!ha) begin fa = nib_in_a; ha = 1'b1; end
        else begin qa.push_back({nib_in_a, fa}); ha = 1'b0; end
      end
      if (nib_valid_b && rdy_b) begin
        if (!hb) begin fb = nib_in_b; hb = 1'b1; end
        else begin qb.push_back({fb, nib_in_b}); hb = 1'b0; end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] sent[$];
  logic [7:0] rx[$];
  bit stream_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_a(input logic [3:0] n);
    int t = 0;
    nib_in_a = n; nib_valid_a = 1'b1;
    while (1) begin
      @(negedge clk);
      if (nib_ready_a) break;
      t++;
      if (t > 200) begin chk("send_a_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    nib_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] n);
    int t = 0;
    nib_in_b = n; nib_valid_b = 1'b1;
    while (1) begin
      @(negedge clk);
      if (nib_ready_b) break;
      t++;
      if (t > 200) begin chk("send_b_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    nib_valid_b = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    nib_in_a = 4'h0; nib_in_b = 4'h0;
    nib_valid_a = 1'b0; nib_valid_b = 1'b0;
    out_ready_a = 1'b0; out_ready_b = 1'b0;
    stream_done = 1'b0;

    // Per-cycle comparison against the model, plus capture of accepted output bytes.
    fork
      forever begin
        @(negedge clk);
        chk("a_nib_ready", nib_ready_a, !(ha && qa.size() == DA));
        chk("a_out_valid", out_valid_a, qa.size() != 0);
        chk("a_data_out",  data_out_a,  (qa.size() != 0) ? qa[0] : 8'h00);
        chk("a_half_pend", half_pend_a, ha);
        chk("a_byte_cnt",  byte_cnt_a,  ca);
        chk("b_nib_ready", nib_ready_b, !(hb && qb.size() == DB));
        chk("b_out_valid", out_valid_b, qb.size() != 0);
        chk("b_data_out",  data_out_b,  (qb.size() != 0) ? qb[0] : 8'h00);
        chk("b_half_pend", half_pend_b, hb);
        chk("b_byte_cnt",  byte_cnt_b,  cb);
        if (rst_n && !flush && out_valid_a && out_ready_a) rx.push_back(data_out_a);
      end
    join_none

    // Reset values.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_nib_ready", nib_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_data_out", data_out_a, 8'h00);
    chk("rst_half_pend", half_pend_a, 0);
    chk("rst_byte_cnt", byte_cnt_a, 8'h00);
    step();
    rst_n = 1'b1;

    // SWAP=1: 0x5 then 0xA gives 0xA5; popped on the following edge.
    out_ready_a = 1'b1;
    send_a(4'h5);
    chk("swap_half_pend", half_pend_a, 1);
    send_a(4'hA);
    chk("swap_out_valid", out_valid_a, 1);
    chk("swap_data_out", data_out_a, 8'hA5);
    step();
    chk("swap_byte_cnt", byte_cnt_a, 1);
    chk("swap_drained", out_valid_a, 0);

    // SWAP=0: 0x5 then 0xA gives 0x5A.
    out_ready_b = 1'b1;
    send_b(4'h5);
    send_b(4'hA);
    chk("pass_data_out", data_out_b, 8'h5A);
    step();

    // Full FIFO with a held nibble blocks the sender until one pop frees a slot.
    out_ready_a = 1'b0;
    send_a(4'h2); send_a(4'h1);
    send_a(4'h4); send_a(4'h3);
    send_a(4'h7);
    chk("full_nib_ready", nib_ready_a, 0);
    chk("full_half_pend", half_pend_a, 1);
    chk("full_head", data_out_a, 8'h12);
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
    chk("freed_nib_ready", nib_ready_a, 1);
    chk("freed_head", data_out_a, 8'h34);
    chk("freed_byte_cnt", byte_cnt_a, 2);
    send_a(4'h8);
    chk("refill_half_pend", half_pend_a, 0);
    chk("refill_head", data_out_a, 8'h34);

    // Flush with a held nibble, two queued bytes and a concurrent pop request.
    send_a(4'h9);
    flush = 1'b1; out_ready_a = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_out_valid", out_valid_a, 0);
    chk("flush_half_pend", half_pend_a, 0);
    chk("flush_byte_cnt", byte_cnt_a, 2);
    out_ready_a = 1'b0;
    send_a(4'h1); send_a(4'h2);
    chk("post_flush_byte", data_out_a, 8'h21);
    out_ready_a = 1'b1;
    step();
    chk("post_flush_cnt", byte_cnt_a, 3);

    // Reset mid-byte: held 0xF is lost.
    send_a(4'hF);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_half_pend", half_pend_a, 0);
    chk("mid_rst_byte_cnt", byte_cnt_a, 0);
    step();
    rst_n = 1'b1;
    out_ready_a = 1'b0;
    send_a(4'h3); send_a(4'h4);
    chk("mid_rst_byte", data_out_a, 8'h43);
    chk("mid_rst_cnt_before_pop", byte_cnt_a, 0);
    out_ready_a = 1'b1;
    step();
    chk("mid_rst_cnt_after_pop", byte_cnt_a, 1);
    chk("mid_rst_empty", out_valid_a, 0);

    // 257-byte stream with random backpressure.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rx.delete();
    fork
      begin
        for (int i = 0; i < 257; i++) begin
          automatic logic [7:0] b = 8'($urandom);
          sent.push_back(b);
          send_a(b[3:0]);
          repeat ($urandom_range(0, 1)) step();
          send_a(b[7:4]);
          repeat ($urandom_range(0, 1)) step();
        end
        for (int t = 0; t < 200 && rx.size() < 257; t++) step();
        step();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          out_ready_a = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready_a = 1'b0;
      end
    join
    chk("stream_len", rx.size(), 257);
    for (int i = 0; i < 257 && i < rx.size(); i++) chk($sformatf("stream_byte_%0d", i), rx[i], sent[i]);
    chk("stream_byte_cnt", byte_cnt_a, 8'h01);
    chk("stream_empty", out_valid_a, 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_unswap_rx.md
NIBBLE_UNSWAP_RX -- requirements
Module: nibble_unswap_rx

Interface
REQ-001 Parameter SWAP, default 1: 1 = restore nibble-swapped bytes; 0 = pass bytes through in arrival order.
REQ-002 Parameter DEPTH, default 2: output byte FIFO depth; legal values 2 and 4 only.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous clear of partial byte and FIFO.
REQ-006 nib_in  input  4  serial nibble data, first nibble of a byte sent first.
REQ-007 nib_valid  input  1  nib_in is valid this cycle.
REQ-008 nib_ready  output  1  block accepts nib_in this cycle.
REQ-009 data_out  output  8  reassembled byte at FIFO head.
REQ-010 out_valid  output  1  data_out holds a valid byte.
REQ-011 out_ready  input  1  consumer accepts data_out this cycle.
REQ-012 byte_cnt  output  8  count of bytes popped from the FIFO, wraps modulo 256.
REQ-013 half_pend  output  1  first nibble of a byte is held, second is outstanding.

Function
REQ-014 Nibble transfer: occurs on a rising edge where nib_valid=1 and nib_ready=1.
REQ-015 Byte transfer: occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-016 FSM state LO_WAIT: waiting for the first nibble of a byte; a nibble transfer latches nib_in into the first-nibble register and moves to HI_WAIT.
REQ-017 FSM state HI_WAIT: waiting for the second nibble; a nibble transfer pushes the assembled byte into the FIFO and returns to LO_WAIT.
REQ-018 Assembly with SWAP=1: byte = {second nibble, first nibble}; the first nibble is the original bits [3:0].
REQ-019 Assembly with SWAP=0: byte = {first nibble, second nibble}.
REQ-020 nib_ready = NOT (state==HI_WAIT AND FIFO count==DEPTH); it is derived from registered state only, with no combinational path from out_ready or nib_valid.
REQ-021 Push latency: a byte completed on edge N appears on data_out with out_valid=1 after edge N when the FIFO was empty; no combinational bypass.
REQ-022 FIFO order: strict first-in first-out; data_out is stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous push and pop on one edge: count unchanged, both operations take effect.
REQ-024 Pop when the FIFO is full: the freed slot is usable by a push on the following edge, since nib_ready reflects the new count.
REQ-025 Pointer wrap: read and write pointers wrap modulo DEPTH; count ranges from 0 to DEPTH inclusive.
REQ-026 byte_cnt: increments by 1 on each byte transfer; 255+1 = 0.
REQ-027 half_pend = 1 exactly when state==HI_WAIT.
REQ-028 flush=1 on an edge: state becomes LO_WAIT, FIFO count becomes 0 and pointers become 0; any concurrent nibble transfer or byte transfer is discarded; byte_cnt is not changed.
REQ-029 out_valid = (count != 0); it is never asserted from an uninitialised entry.
REQ-030 nib_valid while nib_ready=0: the block ignores the nibble; the sender holds the nibble.

Reset
REQ-031 rst_n low: asynchronously sets state LO_WAIT, count 0, pointers 0, byte_cnt 0x00, first-nibble register 0x0.
REQ-032 Output values during and after reset: nib_ready=1, out_valid=0, data_out=0x00, half_pend=0, byte_cnt=0x00.
REQ-033 Reset mid-byte: the held nibble is lost; the first nibble after release is treated as a first nibble.
REQ-034 Reset release: deassertion is synchronised by the environment; the first transfer is accepted on the first edge after release.

Verification
REQ-035 SWAP=1, out_ready=1: nibbles 0x5 then 0xA -> data_out=0xA5 with out_valid=1 one cycle after the second nibble; byte_cnt becomes 1.
REQ-036 SWAP=0: nibbles 0x5 then 0xA -> data_out=0x5A.
REQ-037 DEPTH=2, out_ready=0: send bytes 0x12, 0x34, then one nibble 0x7 -> nib_ready=0 while half_pend=1; assert out_ready for 1 cycle -> 0x12 popped, nib_ready=1 on the next cycle, the following nibble accepted.
REQ-038 flush asserted with half_pend=1 and 2 bytes queued -> next cycle out_valid=0, half_pend=0, byte_cnt unchanged; next pair 0x1,0x2 -> 0x21.
REQ-039 rst_n pulsed low after the first nibble 0xF, then nibbles 0x3, 0x4 -> single byte 0x43; byte_cnt reads 0 before the pop.
REQ-040 Stream 257 bytes with random out_ready backpressure -> output order preserved, no loss or duplication, byte_cnt=0x01.
